uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning maximum payload bytes per frame (1..255).
REQ-002 SHALL have parameter SOF, default 8'hA5, meaning start-of-frame byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100_000, meaning the inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-005 SHALL have port rstn, input, 1, meaning the asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, 8, meaning the received byte from uart_rx.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1), forming the byte handshake; a byte is accepted when in_valid && in_ready.
REQ-008 SHALL have ports frm_valid (output, 1) and frm_ready (input, 1), forming the payload handshake; a beat transfers when both are high.
REQ-009 SHALL have ports frm_cmd (output, 8) and frm_len (output, $clog2(MAX_LEN+1)), both held constant for all beats of one frame.
REQ-010 SHALL have ports frm_data (output, 8) and frm_last (output, 1), meaning the payload byte and the final-beat flag.
REQ-011 SHALL have ports err_chk, err_len and err_timeout (outputs, 1 each), each a single-cycle error pulse.

Function
REQ-012 SHALL implement frame format SOF, CMD, LEN, LEN payload bytes, CHK, where CHK = XOR of CMD, LEN and all payload bytes.
REQ-013 SHALL implement FSM states HUNT, CMD, LEN, PAYLOAD, CHK, EMIT.
REQ-014 SHALL, in HUNT, accept and discard every byte that is not SOF; accepting SOF moves the FSM to CMD.
REQ-015 SHALL, in CMD, latch the byte and seed the running checksum with it, then move to LEN.
REQ-016 SHALL, in LEN, on LEN > MAX_LEN pulse err_len and return to HUNT; on LEN = 0 move to CHK; otherwise move to PAYLOAD.
REQ-017 SHALL, in PAYLOAD, write the byte to buffer index 0..LEN-1 and XOR it into the checksum, moving to CHK after the LEN-th byte.
REQ-018 SHALL treat a SOF value received inside a frame as ordinary data, with no resynchronisation.
REQ-019 SHALL, in CHK, on a match go to EMIT with frm_valid high the next cycle; on a mismatch pulse err_chk, return to HUNT and emit nothing.
REQ-020 SHALL hold in_ready = 1 in HUNT..CHK and in_ready = 0 in EMIT; upstream holds its byte while in_ready is low.
REQ-021 SHALL, in EMIT, present the buffered bytes in order, one per accepted beat, with frm_last on beat LEN-1.
REQ-022 SHALL hold frm_data, frm_last and frm_valid stable while frm_valid && !frm_ready.
REQ-023 SHALL, for LEN = 0, emit exactly one beat with frm_len = 0, frm_data = 0 and frm_last = 1.
REQ-024 SHALL return to HUNT on the cycle the last beat is accepted, with in_ready high the following cycle.
REQ-025 SHALL keep frm_valid = 0 outside EMIT and keep error pulses exactly one cycle wide.

Reset
REQ-026 SHALL, on rstn low at any time including mid-frame or mid-EMIT, immediately force state = HUNT and clear the checksum, index and timeout counters.
REQ-027 SHALL drive these reset output values: frm_valid = 0, frm_data = 0, frm_cmd = 0, frm_len = 0, frm_last = 0, all err_* = 0, in_ready = 1 after release.
REQ-028 SHALL leave buffer contents unreset.

Configuration
REQ-029 SHALL, with macro UART_FRAME_PARSER_TIMEOUT_EN defined, run a counter in CMD..CHK that reloads to TIMEOUT_CYCLES on every accepted byte and decrements each cycle otherwise.
REQ-030 SHALL, when that counter reaches 0, pulse err_timeout and return to HUNT; the counter is idle in HUNT and EMIT.
REQ-031 SHALL, without UART_FRAME_PARSER_TIMEOUT_EN, omit the counter, keep the err_timeout port and tie it to 0.

Structure
REQ-032 SHALL place the state enum, the SOF default and the checksum-width constant in shared package uart_pkg.
REQ-033 SHALL implement the payload store as sub-module uart_frm_buf: MAX_LEN x 8 registers, one synchronous write port, one combinational read port.

Verification
REQ-034 SHALL cover: bytes A5 01 02 11 22 30 -> beats 11 then 22 (last), frm_cmd = 01, frm_len = 2, no error.
REQ-035 SHALL cover: bytes A5 07 00 07 -> one beat with frm_data = 00, frm_last = 1, frm_len = 0.
REQ-036 SHALL cover: bytes A5 01 02 11 22 31 -> err_chk pulses once, no frm_valid, next good frame parses.
REQ-037 SHALL cover: with MAX_LEN = 16, bytes A5 01 11 -> err_len pulses, and a following 3C A5 ... frame parses with 3C discarded.
REQ-038 SHALL cover: frm_ready held low for 10 cycles during EMIT -> data stable, in_ready = 0, upstream byte not lost.
REQ-039 SHALL cover: macro defined, TIMEOUT_CYCLES = 50, bytes A5 01 then idle 60 cycles -> err_timeout pulses once and the FSM returns to HUNT; rstn pulsed mid-PAYLOAD -> HUNT with outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser slice.
package uart_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CHK_W       = 8;
    localparam logic [7:0]  SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/uart_frm_buf.sv
// Payload store: DEPTH x byte registers, one synchronous write port, one combinational read port.
module uart_frm_buf
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data_c
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/CMD/LEN/payload/CHK byte frames and replays verified payloads as beats.
// Optional inter-byte timeout enabled by defining UART_FRAME_PARSER_TIMEOUT_EN.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SOF            = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         frm_valid,
    input  logic                         frm_ready,
    output logic [7:0]                   frm_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] frm_len,
    output logic [7:0]                   frm_data,
    output logic                         frm_last,
    output logic                         err_chk,
    output logic                         err_len,
    output logic                         err_timeout
);

    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t           state, state_n;
    logic [CHK_W-1:0] chk_q, chk_n;
    logic [LEN_W-1:0] idx_q, idx_n;
    logic [LEN_W-1:0] frm_len_n;
    logic [7:0]       frm_cmd_n, frm_data_n;
    logic             in_ready_n, frm_valid_n, frm_last_n, err_chk_n, err_len_n;
    logic             buf_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              acc;

    assign acc = in_valid && in_ready;

    uart_frm_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .we        (buf_we),
        .wr_addr   (ADDR_W'(idx_q)),
        .wr_data   (in_data),
        .rd_addr   (rd_addr),
        .rd_data_c (rd_data)
    );

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_n;
    logic             err_timeout_n;
`else
    // Port kept for a uniform interface; the timeout logic is not built.
    assign err_timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_HUNT;
            chk_q     <= '0;
            idx_q     <= '0;
            in_ready  <= 1'b1;
            frm_valid <= 1'b0;
            frm_cmd   <= '0;
            frm_len   <= '0;
            frm_data  <= '0;
            frm_last  <= 1'b0;
            err_chk   <= 1'b0;
            err_len   <= 1'b0;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
            tmo_q       <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            chk_q     <= chk_n;
            idx_q     <= idx_n;
            in_ready  <= in_ready_n;
            frm_valid <= frm_valid_n;
            frm_cmd   <= frm_cmd_n;
            frm_len   <= frm_len_n;
            frm_data  <= frm_data_n;
            frm_last  <= frm_last_n;
            err_chk   <= err_chk_n;
            err_len   <= err_len_n;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
            tmo_q       <= tmo_n;
            err_timeout <= err_timeout_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        chk_n       = chk_q;
        idx_n       = idx_q;
        frm_valid_n = frm_valid;
        frm_cmd_n   = frm_cmd;
        frm_len_n   = frm_len;
        frm_data_n  = frm_data;
        frm_last_n  = frm_last;
        err_chk_n   = 1'b0;
        err_len_n   = 1'b0;
        buf_we      = 1'b0;
        rd_addr     = '0;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        tmo_n         = tmo_q;
        err_timeout_n = 1'b0;
`endif

        case (state)
            ST_HUNT: begin
                if (acc && (in_data == SOF)) begin
                    state_n = ST_CMD;
                end
            end
            ST_CMD: begin
                if (acc) begin
                    frm_cmd_n = in_data;
                    chk_n     = CHK_W'(in_data);
                    state_n   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (acc) begin
                    if (32'(in_data) > MAX_LEN) begin
                        err_len_n = 1'b1;
                        state_n   = ST_HUNT;
                    end else begin
                        frm_len_n = LEN_W'(in_data);
                        chk_n     = chk_q ^ CHK_W'(in_data);
                        idx_n     = '0;
                        state_n   = (in_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (acc) begin
                    buf_we = 1'b1;
                    chk_n  = chk_q ^ CHK_W'(in_data);
                    if ((idx_q + LEN_W'(1)) == frm_len) begin
                        state_n = ST_CHK;
                    end else begin
                        idx_n = idx_q + LEN_W'(1);
                    end
                end
            end
            ST_CHK: begin
                if (acc) begin
                    if (CHK_W'(in_data) == chk_q) begin
                        // First beat is staged here so frm_valid rises on the next cycle.
                        state_n     = ST_EMIT;
                        idx_n       = '0;
                        frm_valid_n = 1'b1;
                        frm_data_n  = (frm_len == '0) ? 8'h00 : rd_data;
                        frm_last_n  = (frm_len <= LEN_W'(1));
                    end else begin
                        err_chk_n = 1'b1;
                        state_n   = ST_HUNT;
                    end
                end
            end
            ST_EMIT: begin
                if (frm_valid && frm_ready) begin
                    if (frm_last) begin
                        state_n     = ST_HUNT;
                        frm_valid_n = 1'b0;
                        frm_last_n  = 1'b0;
                    end else begin
                        idx_n      = idx_q + LEN_W'(1);
                        rd_addr    = ADDR_W'(idx_q + LEN_W'(1));
                        frm_data_n = rd_data;
                        frm_last_n = ((idx_q + LEN_W'(2)) == frm_len);
                    end
                end
            end
            default: state_n = ST_HUNT;
        endcase

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        // Reload on every accepted byte; count down only while inside a frame.
        if (acc) begin
            tmo_n = TMO_W'(TIMEOUT_CYCLES);
        end else if ((state == ST_CMD) || (state == ST_LEN) ||
                     (state == ST_PAYLOAD) || (state == ST_CHK)) begin
            if (tmo_q == '0) begin
                err_timeout_n = 1'b1;
                state_n       = ST_HUNT;
            end else begin
                tmo_n = tmo_q - TMO_W'(1);
            end
        end
`endif

        in_ready_n = (state_n != ST_EMIT);
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a stream-level frame model and event scoreboard.
module tb_uart_frame_parser;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  SOF     = 8'hA5;
    localparam int unsigned TMO     = 50;

    typedef enum int {EV_BEAT, EV_CHK, EV_LEN, EV_TMO} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [24:0] beat;
    } ev_t;
    typedef logic [7:0] bytes_t [$];

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             frm_valid;
    logic             frm_ready = 1'b1;
    logic [7:0]       frm_cmd;
    logic [LEN_W-1:0] frm_len;
    logic [7:0]       frm_data;
    logic             frm_last;
    logic             err_chk, err_len, err_timeout;

    int vectors = 0;
    int miscompares = 0;
    int ready_mode = 0;
    int err_chk_cnt = 0, err_len_cnt = 0, err_tmo_cnt = 0;
    ev_t expq [$];
    logic [24:0] beat_log [$];

    logic        stall_prev = 1'b0;
    logic        last_prev  = 1'b0;
    logic [22:0] hold_pack  = '0;

    uart_frame_parser #(
        .MAX_LEN        (MAX_LEN),
        .SOF            (SOF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .frm_cmd     (frm_cmd),
        .frm_len     (frm_len),
        .frm_data    (frm_data),
        .frm_last    (frm_last),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       frm_ready = 1'b1;
            1:       frm_ready = 1'b0;
            default: frm_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] pack_beat(input logic [7:0] cmd, input int len,
                                              input logic [7:0] data, input logic last);
        return {cmd, 8'(len), data, last};
    endfunction

    function automatic void push_ev(input ev_kind_t k, input logic [24:0] b);
        ev_t e;
        e.kind = k;
        e.beat = b;
        expq.push_back(e);
    endfunction

    // Frame-rule model: walks a byte stream and lists the beats/errors it must produce.
    function automatic void model(input bytes_t s);
        int i;
        int len;
        logic [7:0] cmd, x;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != SOF) begin
                i++;
                continue;
            end
            if (i + 2 >= s.size()) return;
            cmd = s[i+1];
            len = int'(s[i+2]);
            i += 3;
            if (len > int'(MAX_LEN)) begin
                push_ev(EV_LEN, '0);
                continue;
            end
            if (i + len >= s.size()) return;
            x = cmd ^ 8'(len);
            for (int k = 0; k < len; k++) x ^= s[i+k];
            if (x != s[i+len]) push_ev(EV_CHK, '0);
            else if (len == 0) push_ev(EV_BEAT, pack_beat(cmd, 0, 8'h00, 1'b1));
            else for (int k = 0; k < len; k++)
                push_ev(EV_BEAT, pack_beat(cmd, len, s[i+k], (k == len - 1)));
            i += len + 1;
        end
    endfunction

    task automatic expect_event(input ev_kind_t k, input logic [24:0] b);
        ev_t e;
        if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d beat %h, required no event", k, b);
            return;
        end
        e = expq.pop_front();
        check("event_kind", 64'(k), 64'(e.kind));
        if (k == EV_BEAT && e.kind == EV_BEAT) check("beat", 64'(b), 64'(e.beat));
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            stall_prev = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {frm_valid, frm_cmd, frm_len, frm_data, frm_last}, hold_pack);
            if (last_prev)
                check("ready_after_last", {in_ready, frm_valid}, 2'b10);
            if (frm_valid)
                check("in_ready_in_emit", in_ready, 1'b0);
            if (frm_valid && frm_ready) begin
                beat_log.push_back(pack_beat(frm_cmd, int'(frm_len), frm_data, frm_last));
                expect_event(EV_BEAT, pack_beat(frm_cmd, int'(frm_len), frm_data, frm_last));
            end
            if (err_chk) begin
                err_chk_cnt++;
                expect_event(EV_CHK, '0);
            end
            if (err_len) begin
                err_len_cnt++;
                expect_event(EV_LEN, '0);
            end
            if (err_timeout) begin
                err_tmo_cnt++;
                expect_event(EV_TMO, '0);
            end
            stall_prev = frm_valid && !frm_ready;
            last_prev  = frm_valid && frm_ready && frm_last;
            hold_pack  = {frm_valid, frm_cmd, frm_len, frm_data, frm_last};
        end
    end

    function automatic logic [24:0] log_at(input int i);
        return (i < beat_log.size()) ? beat_log[i] : '1;
    endfunction

    task automatic clear_logs();
        beat_log.delete();
        err_chk_cnt = 0;
        err_len_cnt = 0;
        err_tmo_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: in_ready stayed 0, required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_raw(input bytes_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic run(input bytes_t s);
        model(s);
        send_raw(s);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || frm_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        check("drain_pending", 64'(expq.size()), 64'd0);
        expq.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("reset_outputs",
              {frm_valid, frm_data, frm_cmd, frm_len, frm_last, err_chk, err_len, err_timeout}, '0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1'b1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        bytes_t s;
        logic [7:0] x, b;

        // Reset state
        #2;
        check("reset_outputs",
              {frm_valid, frm_data, frm_cmd, frm_len, frm_last, err_chk, err_len, err_timeout}, '0);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1'b1);

        // Two-byte payload
        clear_logs();
        s = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
        run(s);
        drain();
        check("t1_nbeats", 64'(beat_log.size()), 64'd2);
        check("t1_beat0", log_at(0), {8'h01, 8'h02, 8'h11, 1'b0});
        check("t1_beat1", log_at(1), {8'h01, 8'h02, 8'h22, 1'b1});

        // Zero-length frame
        clear_logs();
        s = '{8'hA5, 8'h07, 8'h00, 8'h07};
        run(s);
        drain();
        check("t2_nbeats", 64'(beat_log.size()), 64'd1);
        check("t2_beat0", log_at(0), {8'h07, 8'h00, 8'h00, 1'b1});

        // Bad checksum then good frame
        clear_logs();
        s = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31,
              8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
        run(s);
        drain();
        check("t3_err_chk", 64'(err_chk_cnt), 64'd1);
        check("t3_nbeats", 64'(beat_log.size()), 64'd2);

        // LEN = 17 rejected; junk discarded; SOF value inside payload is data
        clear_logs();
        s = '{8'hA5, 8'h01, 8'h11, 8'h3C, 8'hA5, 8'h02, 8'h01, 8'hA5, 8'hA6};
        run(s);
        drain();
        check("t4_err_len", 64'(err_len_cnt), 64'd1);
        check("t4_beat0", log_at(0), {8'h02, 8'h01, 8'hA5, 1'b1});

        // Backpressure: 10 stalled cycles while the next SOF waits upstream
        clear_logs();
        ready_mode = 1;
        s = '{8'hA5, 8'h03, 8'h03, 8'h10, 8'h20, 8'h30, 8'h00,
              8'hA5, 8'h04, 8'h01, 8'h5A, 8'h5F};
        fork
            run(s);
            begin
                for (int n = 0; n < 300 && !frm_valid; n++) @(negedge clk);
                check("t5_reach_emit", frm_valid, 1'b1);
                repeat (10) begin
                    @(negedge clk);
                    check("t5_in_ready_low", {in_ready, frm_valid}, 2'b01);
                end
                ready_mode = 0;
            end
        join
        drain();
        check("t5_nbeats", 64'(beat_log.size()), 64'd4);
        check("t5_beat2", log_at(2), {8'h03, 8'h03, 8'h30, 1'b1});
        check("t5_beat3", log_at(3), {8'h04, 8'h01, 8'h5A, 1'b1});

        // Junk, MAX_LEN payload and a one-byte frame under random backpressure
        clear_logs();
        ready_mode = 2;
        s = '{8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h33, 8'h10};
        x = 8'h33 ^ 8'h10;
        for (int k = 0; k < 16; k++) begin
            b = 8'(k * 37 + 5);
            s.push_back(b);
            x ^= b;
        end
        s.push_back(x);
        s.push_back(8'hA5); s.push_back(8'h44); s.push_back(8'h01);
        s.push_back(8'hA5); s.push_back(8'hE0);
        run(s);
        drain();
        ready_mode = 0;
        check("t6_nbeats", 64'(beat_log.size()), 64'd17);
        check("t6_beat16", log_at(16), {8'h44, 8'h01, 8'hA5, 1'b1});

        // Reset mid-payload, then a normal frame
        clear_logs();
        s = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22};
        send_raw(s);
        pulse_reset();
        s = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
        run(s);
        drain();
        check("t7_nbeats", 64'(beat_log.size()), 64'd2);

        // Reset mid-EMIT
        clear_logs();
        ready_mode = 1;
        s = '{8'hA5, 8'h05, 8'h01, 8'h77, 8'h73};
        send_raw(s);
        for (int n = 0; n < 20 && !frm_valid; n++) @(negedge clk);
        check("t8_in_emit", frm_valid, 1'b1);
        pulse_reset();
        ready_mode = 0;
        repeat (3) @(negedge clk);
        check("t8_no_replay", 64'(beat_log.size()), 64'd0);
        s = '{8'hA5, 8'h07, 8'h00, 8'h07};
        run(s);
        drain();
        check("t8_nbeats", 64'(beat_log.size()), 64'd1);

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        // Inter-byte timeout
        clear_logs();
        s = '{8'hA5, 8'h01};
        send_raw(s);
        push_ev(EV_TMO, '0);
        repeat (60) @(negedge clk);
        check("t9_err_tmo", 64'(err_tmo_cnt), 64'd1);
        drain();
        s = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
        run(s);
        drain();
        check("t9_nbeats", 64'(beat_log.size()), 64'd2);
`else
        check("t9_err_tmo_tied", 64'(err_tmo_cnt), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
